// File: rtl/num_split_if.sv
// num_split bus: conversion request/value in, BCD digits and status out.
// Latency: none, wires only.
// Backpressure: none; requester watches busy/valid and re-asserts load in IDLE.
interface num_split_if #(
    parameter int NUM_IN_BIT_WIDTH = 8
);
    logic [NUM_IN_BIT_WIDTH-1:0] value_in;
    logic                        load;
    logic                        enable;
    logic [3:0]                  hund_out;
    logic [3:0]                  tens_out;
    logic [3:0]                  unit_out;
    logic                        busy;
    logic                        valid;
    logic [1:0]                  check_state;

    modport master (
        output value_in, load, enable,
        input  hund_out, tens_out, unit_out, busy, valid, check_state
    );

    modport slave (
        input  value_in, load, enable,
        output hund_out, tens_out, unit_out, busy, valid, check_state
    );
endinterface

// File: rtl/num_split.sv
// Binary to 3-digit BCD splitter (double-dabble, one bit per clock); NUM_SPLIT_ZERO_BLANK_EN enables leading-zero blanking.
// Latency: load accepted at edge T -> valid pulse in the cycle after edge T+NUM_IN_BIT_WIDTH.
// Backpressure: none; load is ignored while busy or in DONE, no queueing.
module num_split #(
    parameter int NUM_IN_BIT_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    num_split_if.slave  bus
);
    localparam int NUM_BIT_WIDTH = 4;
    localparam int BCD_W         = 3 * NUM_BIT_WIDTH;
    localparam int CNT_W         = 4;
    localparam int SH_W          = BCD_W + NUM_IN_BIT_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [NUM_IN_BIT_WIDTH-1:0] r_bin;
    logic [BCD_W-1:0]            r_bcd;
    logic [CNT_W-1:0]            r_cnt;
    logic [3:0]                  r_hund;
    logic [3:0]                  r_tens;
    logic [3:0]                  r_unit;

    logic [BCD_W-1:0]            w_adj;
    logic [SH_W-1:0]             w_shift;
    logic [3:0]                  w_hund_fmt;
    logic [3:0]                  w_tens_fmt;
    logic [3:0]                  w_unit_fmt;
    logic                        w_start;
    logic                        w_last;
    logic                        w_busy;
    logic                        w_valid;

    assign w_start = (r_state == S_IDLE) && bus.enable && bus.load;
    assign w_last  = (r_cnt == CNT_W'(NUM_IN_BIT_WIDTH - 1));

    // Add-3 correction on every nibble >= 5 before the shift; no carry crosses nibbles.
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < 3; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5)
                w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
        end
    end

    // Shift the whole {bcd,bin} pair left by one; upper part is the new BCD value.
    assign w_shift = {w_adj, r_bin} << 1;

    // Digit formatting applied at the moment outputs load.
    always_comb begin
        w_unit_fmt = w_shift[SH_W-9 -: 4];
        w_tens_fmt = w_shift[SH_W-5 -: 4];
        w_hund_fmt = w_shift[SH_W-1 -: 4];
`ifdef NUM_SPLIT_ZERO_BLANK_EN
        if (w_shift[SH_W-1 -: 4] == 4'd0) begin
            w_hund_fmt = 4'hF;
            if (w_shift[SH_W-5 -: 4] == 4'd0)
                w_tens_fmt = 4'hF;
        end
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic; the unused encoding falls back to IDLE.
    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
            S_IDLE:  w_state_nxt = w_start ? S_SHIFT : S_IDLE;
            S_SHIFT: w_state_nxt = w_last  ? S_DONE  : S_SHIFT;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        w_busy  = 1'b0;
        w_valid = 1'b0;
        case (r_state)
            S_SHIFT: w_busy  = 1'b1;
            S_DONE:  w_valid = 1'b1;
            default: ;
        endcase
    end

    // Conversion datapath and output digit registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_hund <= 4'd0;
            r_tens <= 4'd0;
            r_unit <= 4'd0;
        end else if (w_start) begin
            r_bin <= bus.value_in;
            r_bcd <= '0;
            r_cnt <= '0;
        end else if (r_state == S_SHIFT) begin
            r_bcd <= w_shift[SH_W-1 -: BCD_W];
            r_bin <= w_shift[NUM_IN_BIT_WIDTH-1:0];
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_hund <= w_hund_fmt;
                r_tens <= w_tens_fmt;
                r_unit <= w_unit_fmt;
            end
        end
    end

    assign bus.hund_out    = r_hund;
    assign bus.tens_out    = r_tens;
    assign bus.unit_out    = r_unit;
    assign bus.busy        = w_busy;
    assign bus.valid       = w_valid;
    assign bus.check_state = r_state;
endmodule

// File: tb/tb_num_split.sv
// Self-checking bench for num_split: directed vector table, multi-cycle corner sequences, 0..255 sweep.
// Latency: checks valid arrives 9 cycles after acceptance and repeats every 10 with load held.
// Backpressure: checks load ignored when disabled, in SHIFT and in DONE.
module tb_num_split;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    num_split_if #(.NUM_IN_BIT_WIDTH(8)) bus ();
    num_split #(.NUM_IN_BIT_WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [7:0] v;
        int         h;
        int         t;
        int         u;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic int expd(input int h, input int t, input int u);
        int hh;
        int tt;
        hh = h;
        tt = t;
`ifdef NUM_SPLIT_ZERO_BLANK_EN
        if (h == 0) hh = 15;
        if (h == 0 && t == 0) tt = 15;
`endif
        return hh * 256 + tt * 16 + u;
    endfunction

    function automatic int outs();
        return int'({bus.hund_out, bus.tens_out, bus.unit_out});
    endfunction

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (bus.check_state != 2'd0 && k < 30) begin
            @(negedge clk);
            k++;
        end
    endtask

    // One full conversion; returns digits at the valid cycle, latency, busy count, output changes.
    task automatic conv(input logic [7:0] v, output int dig, output int lat,
                        output int nbusy, output int unstable);
        int prev;
        wait_idle();
        bus.value_in = v;
        bus.load     = 1'b1;
        bus.enable   = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        prev     = outs();
        lat      = 1;
        nbusy    = 0;
        unstable = 0;
        while (!bus.valid && lat < 20) begin
            if (bus.busy) nbusy++;
            if (outs() != prev) unstable++;
            @(negedge clk);
            lat++;
        end
        dig = outs();
    endtask

    task automatic wait_valid(output int n);
        n = 1;
        @(negedge clk);
        while (!bus.valid && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int dig, lat, nb, un, n, bad, prev;
        tbl[0]  = '{8'd0,   0, 0, 0};
        tbl[1]  = '{8'd255, 2, 5, 5};
        tbl[2]  = '{8'd99,  0, 9, 9};
        tbl[3]  = '{8'd100, 1, 0, 0};
        tbl[4]  = '{8'd42,  0, 4, 2};
        tbl[5]  = '{8'd7,   0, 0, 7};
        tbl[6]  = '{8'd200, 2, 0, 0};
        tbl[7]  = '{8'd10,  0, 1, 0};
        tbl[8]  = '{8'd5,   0, 0, 5};
        tbl[9]  = '{8'd50,  0, 5, 0};
        tbl[10] = '{8'd199, 1, 9, 9};
        tbl[11] = '{8'd128, 1, 2, 8};

        bus.value_in = 8'd0;
        bus.load     = 1'b0;
        bus.enable   = 1'b0;
        #12;
        chk("reset_digits", outs(), 0);
        chk("reset_state", int'(bus.check_state), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_valid", int'(bus.valid), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table; first entry doubles as the latency check from reset.
        for (int i = 0; i < 12; i++) begin
            conv(tbl[i].v, dig, lat, nb, un);
            chk($sformatf("digits_%0d", tbl[i].v), dig, expd(tbl[i].h, tbl[i].t, tbl[i].u));
            chk($sformatf("latency_%0d", tbl[i].v), lat, 9);
            chk($sformatf("busy_cycles_%0d", tbl[i].v), nb, 8);
            chk($sformatf("stable_%0d", tbl[i].v), un, 0);
        end

        // Load held high: back-to-back conversions every 10 cycles, value change mid-SHIFT.
        wait_idle();
        bus.value_in = 8'd42;
        bus.enable   = 1'b1;
        bus.load     = 1'b1;
        wait_valid(n);
        chk("held_first_digits", outs(), expd(0, 4, 2));
        repeat (4) @(negedge clk);
        chk("held_mid_busy", int'(bus.busy), 1);
        bus.value_in = 8'd7;
        wait_valid(n);
        chk("held_spacing_1", 4 + n, 10);
        chk("held_second_digits", outs(), expd(0, 4, 2));
        wait_valid(n);
        chk("held_spacing_2", n, 10);
        chk("held_third_digits", outs(), expd(0, 0, 7));
        bus.load = 1'b0;

        // Disabled: load must be ignored.
        wait_idle();
        prev         = outs();
        bus.enable   = 1'b0;
        bus.load     = 1'b1;
        bus.value_in = 8'd99;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.check_state != 2'd0 || bus.busy || bus.valid || outs() != prev) bad++;
        end
        chk("disabled_ignored", bad, 0);
        bus.load   = 1'b0;
        bus.enable = 1'b1;

        // Reset during SHIFT cycle 4 aborts the conversion.
        wait_idle();
        bus.value_in = 8'd200;
        bus.load     = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_abort_busy", int'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_digits", outs(), 0);
        chk("abort_state", int'(bus.check_state), 0);
        chk("abort_busy", int'(bus.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.valid || bus.busy) bad++;
        end
        chk("abort_no_valid", bad, 0);
        conv(8'd200, dig, lat, nb, un);
        chk("after_abort_digits", dig, expd(2, 0, 0));
        chk("after_abort_latency", lat, 9);

        // Full sweep against a divide/modulo reference.
        bad = 0;
        for (int v = 0; v < 256; v++) begin
            conv(v[7:0], dig, lat, nb, un);
            chk($sformatf("sweep_%0d", v), dig, expd(v / 100, (v / 10) % 10, v % 10));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
